// File: rtl/shuffle_pkg.sv
// ----------------------------------------------------------------------------
// shuffle_pkg
// Shared definitions for the shuffle index sequencer: default loop size,
// index type and the sequencer FSM state encoding.
// No ports.
// ----------------------------------------------------------------------------
package shuffle_pkg;

    localparam int MAX_ELEMENTS_DEF = 128;
    localparam int IDX_W_DEF        = $clog2(MAX_ELEMENTS_DEF);

    typedef logic [IDX_W_DEF-1:0] idx_t;

    // Explicit 3-bit encoding keeps the state vector compatible with older
    // register maps that expose it as a raw field.
    typedef enum logic [2:0] {
        sIdle       = 3'd0,
        sWaitPerm   = 3'd1,
        sResize     = 3'd2,
        sWaitResize = 3'd3,
        sReq        = 3'd4,
        sStream     = 3'd5,
        sDrain      = 3'd6
    } state_t;

endpackage

// File: rtl/shuffle_idx_outreg.sv
// ----------------------------------------------------------------------------
// shuffle_idx_outreg
// One-entry valid/ready output register carrying a shuffled index and its
// last-of-loop flag.
// Ports:
//   clk_in, rst_n_in   clock, async active-low reset
//   load               capture idx_d/last_d and assert valid
//   flush              drop the held entry (valid and last cleared)
//   ready              downstream accepts the entry when valid
//   idx_d, last_d      next entry
//   valid, idx, last   held entry
// ----------------------------------------------------------------------------
module shuffle_idx_outreg #(
    parameter int W = 7
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         load,
    input  logic         flush,
    input  logic         ready,
    input  logic [W-1:0] idx_d,
    input  logic         last_d,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic         last
);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid <= 1'b0;
            idx   <= '0;
            last  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            idx   <= idx_d;
            last  <= last_d;
        end else if (valid && ready) begin
            // Accepted with nothing to replace it; idx keeps its last value.
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/shuffle_index_sequencer.sv
// ----------------------------------------------------------------------------
// shuffle_index_sequencer
// Consumer-side companion to the Fisher-Yates shuffler. Reads the published
// permutation bank one address per cycle and streams shuffled loop indices
// over valid/ready, while steering the shuffler so the next permutation is
// produced in the background.
//
// Optional feature macro: SHUF_BYPASS_EN
//   adds bypass_in; a loop started with bypass_in=1 streams the identity
//   order 0..N-1 without touching the shuffler.
//
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   loop_start_in           start pulse (honoured in idle only)
//   loop_count_in           trip count minus 1, sampled with loop_start_in
//   bypass_in               (SHUF_BYPASS_EN only) identity order for this loop
//   abort_in                terminate the current loop stream
//   idx_valid_out/idx_ready_in/idx_out/idx_last_out   index stream
//   idle_out                FSM idle
//   num_elements_out        element count minus 1 driven to the shuffler
//   rst_index_out           pulse: shuffler re-indexes to num_elements_out
//   perm_req_out            pulse: shuffler swaps banks, starts new permutation
//   perm_done_in            shuffler permutation-complete pulse
//   addr_out, data_in       bank read port (data_in combinational from addr)
//   num_elements_index_in   element count of the currently published bank
//
// state       | meaning
// ------------+-----------------------------------------------------------
// sIdle       | no loop active, waiting for loop_start_in
// sWaitPerm   | loop requested, shuffler still permuting
// sResize     | pulse rst_index_out to re-init shuffler at the new size
// sWaitResize | wait for the re-sized permutation to finish
// sReq        | pulse perm_req_out; bank swap makes fresh permutation readable
// sStream     | read bank at cnt, load output register
// sDrain      | last index loaded, wait for its acceptance
// ----------------------------------------------------------------------------
module shuffle_index_sequencer
    import shuffle_pkg::*;
#(
    parameter int MAX_ELEMENTS     = MAX_ELEMENTS_DEF,
    parameter int BITS_PER_ELEMENT = $clog2(MAX_ELEMENTS)
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        loop_start_in,
    input  logic [BITS_PER_ELEMENT-1:0] loop_count_in,
`ifdef SHUF_BYPASS_EN
    input  logic                        bypass_in,
`endif
    input  logic                        abort_in,
    output logic                        idx_valid_out,
    input  logic                        idx_ready_in,
    output logic [BITS_PER_ELEMENT-1:0] idx_out,
    output logic                        idx_last_out,
    output logic                        idle_out,
    output logic [BITS_PER_ELEMENT-1:0] num_elements_out,
    output logic                        rst_index_out,
    output logic                        perm_req_out,
    input  logic                        perm_done_in,
    output logic [BITS_PER_ELEMENT-1:0] addr_out,
    input  logic [BITS_PER_ELEMENT-1:0] data_in,
    input  logic [BITS_PER_ELEMENT-1:0] num_elements_index_in
);

    state_t                      state;
    state_t                      state_nxt;
    logic [BITS_PER_ELEMENT-1:0] cnt;
    logic [BITS_PER_ELEMENT-1:0] last_cnt;
    logic                        perm_pending;
    logic                        perm_busy;
    logic                        start;
    logic                        bypass_start;
    logic                        load;
    logic                        flush;
    logic                        at_last;
    logic [BITS_PER_ELEMENT-1:0] idx_d;

    assign start = loop_start_in && (state == sIdle);

`ifdef SHUF_BYPASS_EN
    logic bypass_r;

    assign bypass_start = bypass_in;
    assign idx_d        = bypass_r ? cnt : data_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bypass_r <= 1'b0;
        end else if (start) begin
            bypass_r <= bypass_in;
        end
    end
`else
    assign bypass_start = 1'b0;
    assign idx_d        = data_in;
`endif

    // A done pulse arriving this cycle releases the wait immediately rather
    // than one cycle later through the pending register.
    assign perm_busy = perm_pending && !perm_done_in;

    assign at_last = (cnt == last_cnt);
    assign load    = (state == sStream) && (!idx_valid_out || idx_ready_in);
    assign flush   = abort_in && (state != sIdle);

    assign idle_out      = (state == sIdle);
    assign rst_index_out = (state == sResize);
    assign perm_req_out  = (state == sReq);
    assign addr_out      = cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            sIdle: begin
                if (loop_start_in) begin
                    if (bypass_start) begin
                        state_nxt = sStream;
                    end else if (perm_busy) begin
                        state_nxt = sWaitPerm;
                    end else if (num_elements_index_in != loop_count_in) begin
                        state_nxt = sResize;
                    end else begin
                        state_nxt = sReq;
                    end
                end
            end
            sWaitPerm: begin
                if (!perm_busy) begin
                    state_nxt = (num_elements_index_in != last_cnt) ? sResize : sReq;
                end
            end
            sResize:     state_nxt = sWaitResize;
            sWaitResize: if (!perm_busy) state_nxt = sReq;
            sReq:        state_nxt = sStream;
            sStream:     if (load && at_last) state_nxt = sDrain;
            sDrain: begin
                if (idx_valid_out && idx_ready_in && idx_last_out) begin
                    state_nxt = sIdle;
                end
            end
            default:     state_nxt = sIdle;
        endcase
        if (flush) begin
            state_nxt = sIdle;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= sIdle;
            cnt              <= '0;
            last_cnt         <= '0;
            num_elements_out <= BITS_PER_ELEMENT'(MAX_ELEMENTS - 1);
            // The shuffler permutes on its own right after reset.
            perm_pending     <= 1'b1;
        end else begin
            state <= state_nxt;

            if (rst_index_out || perm_req_out) begin
                perm_pending <= 1'b1;
            end else if (perm_done_in) begin
                perm_pending <= 1'b0;
            end

            if (start) begin
                last_cnt <= loop_count_in;
                cnt      <= '0;
                // A bypass loop leaves the shuffler's size alone so a
                // background permutation is not disturbed.
                if (!bypass_start) begin
                    num_elements_out <= loop_count_in;
                end
            end else if (state == sReq) begin
                cnt <= '0;
            end else if (load && !at_last) begin
                // Holding at last_cnt keeps addr_out stable through drain
                // and keeps cnt from wrapping at MAX_ELEMENTS-1.
                cnt <= cnt + 1'b1;
            end
        end
    end

    shuffle_idx_outreg #(
        .W (BITS_PER_ELEMENT)
    ) u_outreg (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load     (load),
        .flush    (flush),
        .ready    (idx_ready_in),
        .idx_d    (idx_d),
        .last_d   (at_last),
        .valid    (idx_valid_out),
        .idx      (idx_out),
        .last     (idx_last_out)
    );

endmodule

// File: tb/tb_shuffle_index_sequencer.sv
// ----------------------------------------------------------------------------
// tb_shuffle_index_sequencer
// Directed bench for shuffle_index_sequencer. The shuffler is modelled by a
// fixed bank function: bank[a] = (7*a + 3) mod (num_elements_index + 1),
// which is a permutation for every size used here.
// Optional macro SHUF_BYPASS_EN enables the bypass sequence.
// ----------------------------------------------------------------------------
module tb_shuffle_index_sequencer;

    localparam int W = 7;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         loop_start_in;
    logic [W-1:0] loop_count_in;
    logic         abort_in;
    logic         idx_valid_out;
    logic         idx_ready_in;
    logic [W-1:0] idx_out;
    logic         idx_last_out;
    logic         idle_out;
    logic [W-1:0] num_elements_out;
    logic         rst_index_out;
    logic         perm_req_out;
    logic         perm_done_in;
    logic [W-1:0] addr_out;
    logic [W-1:0] data_in;
    logic [W-1:0] num_idx;
`ifdef SHUF_BYPASS_EN
    logic         bypass_in;
`endif

    int checks   = 0;
    int failures = 0;
    int perm_req_cnt = 0;

    always #5 clk_in = ~clk_in;

    function automatic logic [W-1:0] model_data(input logic [W-1:0] a, input logic [W-1:0] n);
        int m;
        m = int'(n) + 1;
        return W'((int'(a) * 7 + 3) % m);
    endfunction

    assign data_in = model_data(addr_out, num_idx);

    always @(negedge clk_in) begin
        if (perm_req_out) perm_req_cnt <= perm_req_cnt + 1;
    end

    shuffle_index_sequencer dut (
        .clk_in                (clk_in),
        .rst_n_in              (rst_n_in),
        .loop_start_in         (loop_start_in),
        .loop_count_in         (loop_count_in),
`ifdef SHUF_BYPASS_EN
        .bypass_in             (bypass_in),
`endif
        .abort_in              (abort_in),
        .idx_valid_out         (idx_valid_out),
        .idx_ready_in          (idx_ready_in),
        .idx_out               (idx_out),
        .idx_last_out          (idx_last_out),
        .idle_out              (idle_out),
        .num_elements_out      (num_elements_out),
        .rst_index_out         (rst_index_out),
        .perm_req_out          (perm_req_out),
        .perm_done_in          (perm_done_in),
        .addr_out              (addr_out),
        .data_in               (data_in),
        .num_elements_index_in (num_idx)
    );

    typedef struct {
        int         count;
        logic [3:0] pat;          // idx_ready_in pattern, bit i used on cycle i mod 4
        bit         waitperm;     // start before the outstanding perm_done_in
        int         pre_wait;     // idle cycles before perm_done_in (normal mode)
        int         abort_after;  // abort after this many accepts, -1 = never
        bit         abort_with_start;
        bit         exp_resize;   // hand-derived: shuffler size differs from count
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_done();
        perm_done_in = 1'b1;
        tick();
        perm_done_in = 1'b0;
    endtask

    task automatic collect(input int c, input logic [3:0] pat, input int abort_after,
                           input bit identity, input string tag);
        int           k = 0;
        int           cyc = 0;
        int           cyc_last = -1;
        bit           held = 1'b0;
        logic [W-1:0] held_idx = '0;
        logic [W-1:0] held_addr = '0;
        logic [W-1:0] exp_idx;
        logic [127:0] seen = '0;
        while (k <= c && cyc < 600) begin
            if (abort_after >= 0 && k == abort_after) begin
                idx_ready_in = 1'b0;
                abort_in = 1'b1;
                tick();
                abort_in = 1'b0;
                check({tag, "_abort_valid"}, int'(idx_valid_out), 0);
                check({tag, "_abort_last"}, int'(idx_last_out), 0);
                check({tag, "_abort_idle"}, int'(idle_out), 1);
                return;
            end
            idx_ready_in = pat[cyc[1:0]];
            if (held) begin
                check({tag, "_hold_valid"}, int'(idx_valid_out), 1);
                check({tag, "_hold_idx"}, int'(idx_out), int'(held_idx));
                check({tag, "_hold_addr"}, int'(addr_out), int'(held_addr));
            end
            if (idx_valid_out) begin
                if (idx_ready_in) begin
                    exp_idx = identity ? W'(k) : model_data(W'(k), W'(c));
                    check({tag, "_idx"}, int'(idx_out), int'(exp_idx));
                    check({tag, "_last"}, int'(idx_last_out), (k == c) ? 1 : 0);
                    check({tag, "_dup"}, int'(seen[idx_out]), 0);
                    seen[idx_out] = 1'b1;
                    k++;
                    held = 1'b0;
                    cyc_last = cyc;
                end else begin
                    held      = 1'b1;
                    held_idx  = idx_out;
                    held_addr = addr_out;
                end
            end
            tick();
            cyc++;
        end
        idx_ready_in = 1'b0;
        check({tag, "_accepted"}, k, c + 1);
        if (pat == 4'b1111) check({tag, "_span"}, cyc_last, c);
        check({tag, "_end_valid"}, int'(idx_valid_out), 0);
        check({tag, "_end_idle"}, int'(idle_out), 1);
    endtask

    task automatic run_loop(input vec_t v, input string tag);
        if (!v.waitperm) begin
            repeat (v.pre_wait) tick();
            pulse_done();
        end
        loop_count_in = W'(v.count);
        loop_start_in = 1'b1;
        abort_in      = v.abort_with_start;
        tick();
        loop_start_in = 1'b0;
        abort_in      = 1'b0;
        check({tag, "_busy"}, int'(idle_out), 0);
        if (v.waitperm) begin
            repeat (5) begin
                check({tag, "_wait_noreq"}, int'(perm_req_out), 0);
                check({tag, "_wait_novalid"}, int'(idx_valid_out), 0);
                tick();
            end
            pulse_done();
        end
        if (v.exp_resize) begin
            check({tag, "_rst_index"}, int'(rst_index_out), 1);
            check({tag, "_resize_noreq"}, int'(perm_req_out), 0);
            tick();
            check({tag, "_num_elements"}, int'(num_elements_out), v.count);
            check({tag, "_rst_index_1cyc"}, int'(rst_index_out), 0);
            num_idx = W'(v.count);
            repeat (3) begin
                check({tag, "_resize_wait"}, int'(perm_req_out), 0);
                tick();
            end
            pulse_done();
        end
        check({tag, "_perm_req"}, int'(perm_req_out), 1);
        tick();
        check({tag, "_perm_req_1cyc"}, int'(perm_req_out), 0);
        check({tag, "_first_novalid"}, int'(idx_valid_out), 0);
        tick();
        check({tag, "_first_valid"}, int'(idx_valid_out), 1);
        collect(v.count, v.pat, v.abort_after, 1'b0, tag);
    endtask

    initial begin
        //           count pat      wp pre ab  aws rsz
        vecs[0] = '{15,  4'b1111, 0, 40, -1, 0,  0};
        vecs[1] = '{15,  4'b1111, 1, 0,  -1, 0,  0};
        vecs[2] = '{31,  4'b1111, 0, 3,  -1, 0,  1};
        vecs[3] = '{7,   4'b1001, 0, 3,  -1, 0,  1};
        vecs[4] = '{0,   4'b1111, 0, 3,  -1, 0,  1};
        vecs[5] = '{127, 4'b1111, 0, 3,  -1, 0,  1};
        vecs[6] = '{9,   4'b1111, 0, 3,  3,  0,  1};
        vecs[7] = '{9,   4'b1111, 1, 0,  -1, 1,  0};

        rst_n_in      = 1'b0;
        loop_start_in = 1'b0;
        loop_count_in = '0;
        abort_in      = 1'b0;
        idx_ready_in  = 1'b0;
        perm_done_in  = 1'b0;
        num_idx       = W'(15);
`ifdef SHUF_BYPASS_EN
        bypass_in     = 1'b0;
`endif
        repeat (3) tick();
        check("rst_idle", int'(idle_out), 1);
        check("rst_num_elements", int'(num_elements_out), 127);
        check("rst_valid", int'(idx_valid_out), 0);
        check("rst_last", int'(idx_last_out), 0);
        check("rst_idx", int'(idx_out), 0);
        check("rst_addr", int'(addr_out), 0);
        check("rst_perm_req", int'(perm_req_out), 0);
        check("rst_rst_index", int'(rst_index_out), 0);
        rst_n_in = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_loop(vecs[i], $sformatf("v%0d", i));
            repeat (2) tick();
        end

`ifdef SHUF_BYPASS_EN
        begin
            int req_before;
            req_before    = perm_req_cnt;
            bypass_in     = 1'b1;
            loop_count_in = W'(4);
            loop_start_in = 1'b1;
            tick();
            loop_start_in = 1'b0;
            bypass_in     = 1'b0;
            check("byp_first_novalid", int'(idx_valid_out), 0);
            tick();
            check("byp_first_valid", int'(idx_valid_out), 1);
            collect(4, 4'b1111, -1, 1'b1, "byp");
            check("byp_no_perm_req", perm_req_cnt, req_before);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shuffle_index_sequencer.md
Name: shuffle_index_sequencer

Overview:
- Consumer-side companion to the Fisher-Yates shuffler.
- Reads the published permutation bank one address per cycle and streams shuffled loop indices to the core over a valid/ready interface.
- Drives the shuffler's element-count, rst_index and perm_req controls so that the next permutation is generated in the background while the current one is consumed.

Parameters:
- MAX_ELEMENTS, 128, maximum loop trip count supported.
- BITS_PER_ELEMENT, $clog2(MAX_ELEMENTS), width of indices, addresses and counts.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  reset; asynchronous assert, active-low.
- loop_start_in  in  1  one-cycle pulse; begin a loop of loop_count_in+1 iterations; ignored unless idle_out=1.
- loop_count_in  in  BITS_PER_ELEMENT  trip count minus 1 (15 means 16 iterations); sampled with loop_start_in.
- abort_in  in  1  terminate the current loop stream.
- idx_valid_out  out  1  idx_out holds a valid index.
- idx_ready_in  in  1  core accepts the index.
- idx_out  out  BITS_PER_ELEMENT  shuffled loop index.
- idx_last_out  out  1  qualifies the final index of a loop.
- idle_out  out  1  FSM is in sIdle.
- num_elements_out  out  BITS_PER_ELEMENT  element count (minus 1) driven to the shuffler.
- rst_index_out  out  1  one-cycle pulse; shuffler re-indexes to num_elements_out.
- perm_req_out  out  1  one-cycle pulse; shuffler swaps banks and starts a new permutation.
- perm_done_in  in  1  shuffler permutation-complete pulse.
- addr_out  out  BITS_PER_ELEMENT  read address into the shuffler output bank.
- data_in  in  BITS_PER_ELEMENT  shuffler read data; combinational from addr_out in the same cycle.
- num_elements_index_in  in  BITS_PER_ELEMENT  element count of the bank currently published.

Behaviour:
- Reset values (rst_n_in=0):
  - All outputs 0, except num_elements_out=MAX_ELEMENTS-1 and idle_out=1.
  - perm_pending=1, because the shuffler self-permutes after reset. cnt=0, last_cnt=0.
- perm_pending register:
  - Set in the cycle perm_req_out or rst_index_out is driven.
  - Cleared on perm_done_in.
  - If set and perm_done_in occur in the same cycle, set wins.
- sIdle:
  - On loop_start_in: latch loop_count_in into last_cnt and num_elements_out.
  - If perm_pending=1, go to sWaitPerm.
  - Else, if num_elements_index_in != loop_count_in, go to sResize.
  - Else go to sReq.
- sWaitPerm: hold until perm_pending=0, then apply the same size check as sIdle.
- sResize:
  - Pulse rst_index_out for 1 cycle (sets perm_pending), then go to sWaitResize.
  - sWaitResize waits for perm_pending=0, then goes to sReq. The shuffler re-inits and re-permutes at the new size.
- sReq:
  - Pulse perm_req_out for 1 cycle and set perm_pending.
  - The shuffler swaps banks, so the freshly permuted bank becomes readable from the next cycle.
  - cnt=0; go to sStream.
- sStream:
  - addr_out=cnt.
  - Output register loads when idx_valid_out=0 or idx_ready_in=1: idx_out<=data_in, idx_last_out<=(cnt==last_cnt), idx_valid_out<=1, and cnt increments.
  - First index is visible 1 cycle after entering sStream.
  - Sustained throughput is 1 index/cycle when idx_ready_in=1.
  - After loading last_cnt, go to sDrain.
- sDrain: when the last index is accepted (valid & ready & last), clear idx_valid_out and go to sIdle.
- idx_valid_out is never deasserted without acceptance, except on abort_in.
- abort_in in any non-idle state:
  - Next cycle: idx_valid_out=0, idx_last_out=0, state=sIdle.
  - A background permutation continues; perm_pending is preserved.
- loop_start_in outside sIdle is ignored. abort_in and loop_start_in together in sIdle: start wins.
- loop_count_in=0 gives a single index with idx_last_out=1. cnt never wraps; the maximum is MAX_ELEMENTS-1.
- idx_out, idx_last_out and addr_out are stable while idx_valid_out=1 and idx_ready_in=0.

Optional Feature:
- Macro SHUF_BYPASS_EN.
- When defined:
  - Adds input port bypass_in (1 bit), sampled with loop_start_in.
  - If bypass_in=1, go directly to sStream without waiting on perm_pending and without pulsing perm_req_out or rst_index_out.
  - idx_out=cnt, giving the identity order 0..N-1.
- When undefined: the port is absent and every loop is shuffled.

Decomposition:
- Package shuffle_pkg:
  - state enum: sIdle, sWaitPerm, sResize, sWaitResize, sReq, sStream, sDrain.
  - MAX_ELEMENTS default.
  - idx_t typedef.
- One natural sub-module: shuffle_idx_outreg, the one-entry valid/ready output register carrying idx and last, with a load enable and flush input.

Test Plan:
- Reset, then perm_done_in after 40 cycles, then loop_start_in with count 15, idx_ready_in=1 -> perm_req_out pulse 1 cycle after start; 16 indices on consecutive cycles equal to the bank contents at addresses 0..15; idx_last_out only on the 16th; back to idle_out=1.
- Second loop_start_in before perm_done_in -> FSM stays in sWaitPerm with no perm_req_out; streaming begins 2 cycles after perm_done_in arrives.
- Model has num_elements_index_in=15, loop_count_in=31 -> rst_index_out pulse, wait for perm_done_in, perm_req_out, then 32 indices with num_elements_out=31.
- idx_ready_in toggled 1,0,0,1 during count 7 -> no index lost or duplicated; idx_out is held during stall cycles; 8 accepted indices form a permutation of 0..7.
- abort_in after 3 accepted indices of count 9 -> idx_valid_out=0 next cycle, idle_out=1; a subsequent loop still waits for the outstanding perm_done_in.
- With SHUF_BYPASS_EN defined, bypass_in=1 and count 4 -> indices 0,1,2,3,4; perm_req_out is never asserted.
